// File: rtl/trn_rx_tlp_engine.sv
// Receive-side TLP engine for the 64-bit TRN RX interface: decodes MRd/MWr hitting one BAR.
// Optional drop counter enabled by defining TRN_RX_STATS_EN.
module trn_rx_tlp_engine #(
  parameter int ADDR_W  = 7,
  parameter int BAR_SEL = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [63:0]       trn_rd,
  input  logic [7:0]        trn_rrem_n,
  input  logic              trn_rsof_n,
  input  logic              trn_reof_n,
  input  logic              trn_rsrc_rdy_n,
  input  logic              trn_rsrc_dsc_n,
  output logic              trn_rdst_rdy_n,
  input  logic [6:0]        trn_rbar_hit_n,
  output logic              req_compl_o,
  input  logic              compl_done_i,
  output logic [2:0]        req_tc_o,
  output logic              req_td_o,
  output logic              req_ep_o,
  output logic [1:0]        req_attr_o,
  output logic [9:0]        req_len_o,
  output logic [15:0]       req_rid_o,
  output logic [7:0]        req_tag_o,
  output logic [3:0]        req_be_o,
  output logic [10:0]       req_addr_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [3:0]        wr_be_o,
  output logic [31:0]       wr_data_o,
  input  logic              wr_busy_i,
  output logic [15:0]       stat_drop_cnt_o
);

  // Handshake: a beat transfers on a clock edge where trn_rsrc_rdy_n==0 and
  // trn_rdst_rdy_n==0; neither side may assume a transfer otherwise.
  typedef enum logic [3:0] {
    IDLE, MRD32, MRD64, MWR32, MWR64_A, MWR64_B, DISCARD, CMPL_WAIT, WR
  } state_t;

  state_t     state_q, state_d;
  logic       rdy_en_q;
  logic       beat, sof, eof, hdr_ok, supported;
  logic       idle_sof, sof_drop, rx_abort, a64_short;
  logic [1:0] fmt;
  logic [9:0] len;
  logic       ep;
  logic       unused_sig;

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  assign fmt = trn_rd[62:61];
  assign len = trn_rd[41:32];
  assign ep  = trn_rd[46];
  assign sof = !trn_rsof_n;
  assign eof = !trn_reof_n;

  assign trn_rdst_rdy_n = !(rdy_en_q && (state_q != CMPL_WAIT) && (state_q != WR));
  assign beat           = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;

  assign hdr_ok    = !trn_rbar_hit_n[BAR_SEL] && (trn_rd[60:56] == 5'd0);
  assign supported = hdr_ok && (!fmt[1] || ((len == 10'd1) && !ep));
  assign idle_sof  = (state_q == IDLE) && beat && sof;
  // Unsupported headers, and supported ones truncated at SOF, are both drops.
  assign sof_drop  = idle_sof && !(supported && !eof);
  assign rx_abort  = !trn_rsrc_dsc_n &&
                     (state_q inside {MRD32, MRD64, MWR32, MWR64_A, MWR64_B, DISCARD});
  assign a64_short = (state_q == MWR64_A) && beat && eof;

  assign req_compl_o = (state_q == CMPL_WAIT);
  assign wr_en_o     = (state_q == WR);

  assign unused_sig = ^{trn_rrem_n, trn_rbar_hit_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (idle_sof) begin
          if (sof_drop) begin
            state_d = eof ? IDLE : DISCARD;
          end else begin
            case (fmt)
              2'b00:   state_d = MRD32;
              2'b01:   state_d = MRD64;
              2'b10:   state_d = MWR32;
              default: state_d = MWR64_A;
            endcase
          end
        end
      end
      MRD32, MRD64: begin
        if (rx_abort)  state_d = IDLE;
        else if (beat) state_d = CMPL_WAIT;
      end
      MWR32, MWR64_B: begin
        if (rx_abort)  state_d = IDLE;
        else if (beat) state_d = WR;
      end
      MWR64_A: begin
        if (rx_abort || a64_short) state_d = IDLE;
        else if (beat)             state_d = MWR64_B;
      end
      DISCARD: begin
        if (rx_abort || (beat && eof)) state_d = IDLE;
      end
      CMPL_WAIT: begin
        if (compl_done_i) state_d = IDLE;
      end
      WR: begin
        if (!wr_busy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request fields are only loaded in IDLE/receive states, so they hold while req_compl_o is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_tc_o   <= '0;
      req_td_o   <= 1'b0;
      req_ep_o   <= 1'b0;
      req_attr_o <= '0;
      req_len_o  <= '0;
      req_rid_o  <= '0;
      req_tag_o  <= '0;
      req_be_o   <= '0;
      req_addr_o <= '0;
      wr_addr_o  <= '0;
      wr_be_o    <= '0;
      wr_data_o  <= '0;
    end else begin
      if (idle_sof && !sof_drop) begin
        if (!fmt[1]) begin
          req_tc_o   <= trn_rd[54:52];
          req_td_o   <= trn_rd[47];
          req_ep_o   <= trn_rd[46];
          req_attr_o <= trn_rd[45:44];
          req_len_o  <= trn_rd[41:32];
          req_rid_o  <= trn_rd[31:16];
          req_tag_o  <= trn_rd[15:8];
          req_be_o   <= trn_rd[3:0];
        end else begin
          wr_be_o    <= trn_rd[3:0];
        end
      end
      if (beat && trn_rsrc_dsc_n) begin
        case (state_q)
          MRD32:   req_addr_o <= trn_rd[44:34];
          MRD64:   req_addr_o <= trn_rd[12:2];
          MWR32: begin
            wr_addr_o <= trn_rd[ADDR_W+33:34];
            wr_data_o <= bswap(trn_rd[31:0]);
          end
          MWR64_A: wr_addr_o <= trn_rd[ADDR_W+1:2];
          MWR64_B: wr_data_o <= bswap(trn_rd[63:32]);
          default: ;
        endcase
      end
    end
  end

`ifdef TRN_RX_STATS_EN
  logic        drop_evt;
  logic [15:0] drop_cnt_q;

  // An abort inside DISCARD was already counted when the header was rejected.
  assign drop_evt = sof_drop || (rx_abort && (state_q != DISCARD)) || a64_short;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (drop_evt && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign stat_drop_cnt_o = drop_cnt_q;
`else
  assign stat_drop_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_trn_rx_tlp_engine.sv
// Directed bench for trn_rx_tlp_engine: MRd/MWr decode, busy stall, drops, discontinue, gapped beats.
module tb_trn_rx_tlp_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] trn_rd = '0;
  logic [7:0]  trn_rrem_n = 8'h00;
  logic        trn_rsof_n = 1'b1;
  logic        trn_reof_n = 1'b1;
  logic        trn_rsrc_rdy_n = 1'b1;
  logic        trn_rsrc_dsc_n = 1'b1;
  logic        trn_rdst_rdy_n;
  logic [6:0]  trn_rbar_hit_n = 7'h7E;
  logic        req_compl_o;
  logic        compl_done_i = 1'b0;
  logic [2:0]  req_tc_o;
  logic        req_td_o;
  logic        req_ep_o;
  logic [1:0]  req_attr_o;
  logic [9:0]  req_len_o;
  logic [15:0] req_rid_o;
  logic [7:0]  req_tag_o;
  logic [3:0]  req_be_o;
  logic [10:0] req_addr_o;
  logic        wr_en_o;
  logic [6:0]  wr_addr_o;
  logic [3:0]  wr_be_o;
  logic [31:0] wr_data_o;
  logic        wr_busy_i = 1'b0;
  logic [15:0] stat_drop_cnt_o;

  trn_rx_tlp_engine dut (
    .clk(clk), .rst_n(rst_n), .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n),
    .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n), .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
    .trn_rsrc_dsc_n(trn_rsrc_dsc_n), .trn_rdst_rdy_n(trn_rdst_rdy_n),
    .trn_rbar_hit_n(trn_rbar_hit_n), .req_compl_o(req_compl_o), .compl_done_i(compl_done_i),
    .req_tc_o(req_tc_o), .req_td_o(req_td_o), .req_ep_o(req_ep_o), .req_attr_o(req_attr_o),
    .req_len_o(req_len_o), .req_rid_o(req_rid_o), .req_tag_o(req_tag_o), .req_be_o(req_be_o),
    .req_addr_o(req_addr_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_be_o(wr_be_o),
    .wr_data_o(wr_data_o), .wr_busy_i(wr_busy_i), .stat_drop_cnt_o(stat_drop_cnt_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

`ifdef TRN_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int compared = 0;
  int mismatched = 0;
  int wr_count = 0;
  int compl_count = 0;
  logic req_prev = 1'b0;
  bit gap_mode = 1'b0;
  logic [42:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_drop(input int n);
    return STATS ? 16'(n) : 16'h0000;
  endfunction

  function automatic logic [63:0] hdr(input logic [1:0] fmt, input logic [9:0] len,
                                      input logic ep, input logic [7:0] tag, input logic [3:0] be);
    return {1'b0, fmt, 5'd0, 1'b0, 3'd2, 4'd0, 1'b1, ep, 2'b01, 2'b00, len,
            16'h0100, tag, 4'h0, be};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: present one beat, wait for dst ready (bounded), complete it on the next edge.
  task automatic send_beat(input logic [63:0] d, input logic sof, input logic eof,
                           input logic dsc);
    int n;
    trn_rd = d;
    trn_rsof_n = !sof;
    trn_reof_n = !eof;
    trn_rsrc_dsc_n = !dsc;
    trn_rsrc_rdy_n = 1'b0;
    n = 0;
    while (trn_rdst_rdy_n !== 1'b0 && n < 50) begin
      step();
      n++;
    end
    chk("beat_accept_wait", (n < 50), 1);
    step();
    trn_rsrc_rdy_n = 1'b1;
    trn_rsof_n = 1'b1;
    trn_reof_n = 1'b1;
    trn_rsrc_dsc_n = 1'b1;
    if (gap_mode) step();
  endtask

  // Scoreboard: every completed register write must match the head of exp_q.
  always @(negedge clk) begin
    if (rst_n && wr_en_o && !wr_busy_i) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {wr_addr_o, wr_be_o, wr_data_o}, 43'h0);
      end else begin
        chk("write_contents", {wr_addr_o, wr_be_o, wr_data_o}, exp_q.pop_front());
      end
    end
    if (req_compl_o && !req_prev) compl_count++;
    req_prev <= req_compl_o;
  end

  initial begin
    // Reset state
    repeat (2) step();
    chk("rst_rdst_rdy_n", trn_rdst_rdy_n, 1);
    chk("rst_req_compl", req_compl_o, 0);
    chk("rst_wr_en", wr_en_o, 0);
    chk("rst_req_addr", req_addr_o, 0);
    chk("rst_wr_data", wr_data_o, 0);
    chk("rst_drop_cnt", stat_drop_cnt_o, 0);
    rst_n = 1'b1;
    chk("rdy_at_release", trn_rdst_rdy_n, 1);
    step();
    chk("rdy_after_release", trn_rdst_rdy_n, 0);

    // MRd32 at 0x10, tag 5A
    send_beat(hdr(2'b00, 10'd1, 1'b0, 8'h5A, 4'hF), 1, 0, 0);
    send_beat({32'h0000_0010, 32'h0}, 0, 1, 0);
    chk("mrd_req_compl", req_compl_o, 1);
    chk("mrd_req_addr", req_addr_o, 11'h004);
    chk("mrd_req_tag", req_tag_o, 8'h5A);
    chk("mrd_req_rid", req_rid_o, 16'h0100);
    chk("mrd_req_len", req_len_o, 10'd1);
    chk("mrd_req_be", req_be_o, 4'hF);
    chk("mrd_req_tc", req_tc_o, 3'd2);
    chk("mrd_req_td", req_td_o, 1);
    chk("mrd_req_ep", req_ep_o, 0);
    chk("mrd_req_attr", req_attr_o, 2'b01);
    chk("mrd_rdy_blocked", trn_rdst_rdy_n, 1);
    repeat (3) step();
    chk("mrd_req_held", req_compl_o, 1);
    chk("mrd_rdy_held", trn_rdst_rdy_n, 1);
    chk("mrd_addr_held", req_addr_o, 11'h004);
    compl_done_i = 1'b1;
    step();
    compl_done_i = 1'b0;
    chk("mrd_req_released", req_compl_o, 0);
    chk("mrd_rdy_released", trn_rdst_rdy_n, 0);
    chk("mrd_compl_count", compl_count, 1);

    // MWr32 at 0x8, data 11223344
    exp_q.push_back({7'd2, 4'hF, 32'h4433_2211});
    send_beat(hdr(2'b10, 10'd1, 1'b0, 8'h01, 4'hF), 1, 0, 0);
    send_beat({32'h0000_0008, 32'h1122_3344}, 0, 1, 0);
    chk("mwr32_wr_en", wr_en_o, 1);
    chk("mwr32_wr_addr", wr_addr_o, 7'd2);
    chk("mwr32_wr_data", wr_data_o, 32'h4433_2211);
    chk("mwr32_wr_be", wr_be_o, 4'hF);
    step();
    chk("mwr32_pulse_end", wr_en_o, 0);
    chk("mwr32_wr_count", wr_count, 1);

    // MWr64 at 0xC with register file busy for 5 cycles
    wr_busy_i = 1'b1;
    exp_q.push_back({7'd3, 4'h3, 32'hEFBE_ADDE});
    send_beat(hdr(2'b11, 10'd1, 1'b0, 8'h02, 4'h3), 1, 0, 0);
    send_beat({32'h0000_0000, 32'h0000_000C}, 0, 0, 0);
    send_beat({32'hDEAD_BEEF, 32'h0}, 0, 1, 0);
    chk("busy_wr_en", wr_en_o, 1);
    chk("busy_rdy", trn_rdst_rdy_n, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("busy_wr_en_held", wr_en_o, 1);
      chk("busy_rdy_held", trn_rdst_rdy_n, 1);
    end
    chk("busy_wr_addr", wr_addr_o, 7'd3);
    chk("busy_no_write_yet", wr_count, 1);
    wr_busy_i = 1'b0;
    step();
    chk("busy_wr_en_end", wr_en_o, 0);
    chk("busy_wr_count", wr_count, 2);

    // Drops: MWr32 len=2, then MRd32 missing the BAR
    send_beat(hdr(2'b10, 10'd2, 1'b0, 8'h03, 4'hF), 1, 0, 0);
    send_beat({32'h0000_0008, 32'h5566_7788}, 0, 0, 0);
    send_beat({32'h99AA_BBCC, 32'h0}, 0, 1, 0);
    trn_rbar_hit_n = 7'h7F;
    send_beat(hdr(2'b00, 10'd1, 1'b0, 8'h04, 4'hF), 1, 0, 0);
    send_beat({32'h0000_0010, 32'h0}, 0, 1, 0);
    trn_rbar_hit_n = 7'h7E;
    step();
    chk("drop_wr_count", wr_count, 2);
    chk("drop_compl_count", compl_count, 1);
    chk("drop_req_compl", req_compl_o, 0);
    chk("drop_rdy", trn_rdst_rdy_n, 0);
    chk("drop_cnt_2", stat_drop_cnt_o, exp_drop(2));

    // Discontinue on MWr32 data beat, then MRd32 immediately
    send_beat(hdr(2'b10, 10'd1, 1'b0, 8'h05, 4'hF), 1, 0, 0);
    send_beat({32'h0000_0020, 32'hCAFE_F00D}, 0, 1, 1);
    send_beat(hdr(2'b00, 10'd1, 1'b0, 8'h33, 4'hF), 1, 0, 0);
    send_beat({32'h0000_0040, 32'h0}, 0, 1, 0);
    chk("dsc_req_compl", req_compl_o, 1);
    chk("dsc_req_tag", req_tag_o, 8'h33);
    chk("dsc_req_addr", req_addr_o, 11'h010);
    chk("dsc_wr_count", wr_count, 2);
    compl_done_i = 1'b1;
    step();
    compl_done_i = 1'b0;
    chk("dsc_req_released", req_compl_o, 0);
    chk("dsc_drop_cnt", stat_drop_cnt_o, exp_drop(3));

    // MRd truncated at SOF, then an MWr32 with EP set
    send_beat(hdr(2'b00, 10'd1, 1'b0, 8'h06, 4'hF), 1, 1, 0);
    chk("short_req_compl", req_compl_o, 0);
    chk("short_rdy", trn_rdst_rdy_n, 0);
    send_beat(hdr(2'b10, 10'd1, 1'b1, 8'h07, 4'hF), 1, 0, 0);
    send_beat({32'h0000_0004, 32'h0BAD_0BAD}, 0, 1, 0);
    step();
    chk("ep_wr_count", wr_count, 2);
    chk("ep_compl_count", compl_count, 2);
    chk("ep_drop_cnt", stat_drop_cnt_o, exp_drop(5));

    // MWr64 at 0x14 ungapped, then with trn_rsrc_rdy_n toggling
    for (int g = 0; g < 2; g++) begin
      gap_mode = (g == 1);
      exp_q.push_back({7'd5, 4'hC, 32'hD4C3_B2A1});
      send_beat(hdr(2'b11, 10'd1, 1'b0, 8'h08, 4'hC), 1, 0, 0);
      send_beat({32'h0000_0000, 32'h0000_0014}, 0, 0, 0);
      send_beat({32'hA1B2_C3D4, 32'h0}, 0, 1, 0);
      step();
      chk(gap_mode ? "gap_wr_count" : "nogap_wr_count", wr_count, 3 + g);
      chk(gap_mode ? "gap_wr_addr" : "nogap_wr_addr", wr_addr_o, 7'd5);
      chk(gap_mode ? "gap_wr_data" : "nogap_wr_data", wr_data_o, 32'hD4C3_B2A1);
      chk(gap_mode ? "gap_wr_en_idle" : "nogap_wr_en_idle", wr_en_o, 0);
    end
    gap_mode = 1'b0;
    chk("final_drop_cnt", stat_drop_cnt_o, exp_drop(5));
    chk("exp_q_empty", exp_q.size(), 0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
